// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: word width, default
// reset PC and halt opcode, the fetch FSM encoding and the buffered entry.
package fetch_pc_ctrl_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC   = 16'h0000;
  localparam logic [3:0]        DEFAULT_HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  // One fetched instruction together with its address and fall-through PC.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus_2;
  } fetch_entry_t;

  // Next sequential instruction address; wraps FFFE -> 0000.
  function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(2);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry fetch buffer: OUT is what decode sees, PEND catches the one word
// that arrives while decode is stalled. A pop refills OUT on the same edge,
// from PEND first, otherwise straight from the incoming push.
module fetch_skid_buf
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [15:0] push_instr,
  input  logic [15:0] push_pc,
  input  logic [15:0] push_pc_plus_2,
  input  logic        pop,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic [15:0] out_pc_plus_2
);

  fetch_entry_t out_q;
  fetch_entry_t pend_q;
  fetch_entry_t push_entry;
  logic         pend_valid;
  logic         out_free;

  assign push_entry = '{instr: push_instr, pc: push_pc, pc_plus_2: push_pc_plus_2};
  // OUT can take a new word when it is empty or being consumed this edge.
  assign out_free   = !out_valid || pop;

  // OUT/PEND update: flush drops everything, otherwise keep program order.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would let PEND->OUT and push race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data fields are reset too because decode-visible
      // if_instr/if_pc/if_pc_plus_2 must read zero out of reset.
      out_valid  <= 1'b0;
      pend_valid <= 1'b0;
      out_q      <= '0;
      pend_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      pend_valid <= 1'b0;
    end else if (out_free) begin
      if (pend_valid) begin
        out_q      <= pend_q;
        out_valid  <= 1'b1;
        pend_valid <= push;
        if (push) pend_q <= push_entry;
      end else begin
        out_valid <= push;
        if (push) out_q <= push_entry;
      end
    end else if (push) begin
      pend_q     <= push_entry;
      pend_valid <= 1'b1;
    end
  end

  assign out_instr     = out_q.instr;
  assign out_pc        = out_q.pc;
  assign out_pc_plus_2 = out_q.pc_plus_2;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the architectural PC, issues req/ack fetches to
// instruction memory, buffers up to two words for decode, squashes wrong-path
// fetches on redirect and parks on a HLT opcode until redirected or reset.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = DEFAULT_HLT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus_2,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  squash_addr_q;   // address of the request being discarded
  logic [15:0]  target_pc;
  logic         req_active;
  logic         consume;
  logic         fetch_push;
  logic         is_hlt;

  assign target_pc  = redirect_pc & 16'hFFFE;
  assign req_active = (state_q == ST_FETCH) || (state_q == ST_SQUASH);
  // Request is masked while reset is held so memory sees no fetch then.
  assign imem_req   = req_active && !rst;
  assign imem_addr  = (state_q == ST_SQUASH) ? squash_addr_q : pc_q;
  assign consume    = if_valid && !stall;
  assign is_hlt     = (imem_rdata[15:12] == HLT_OPCODE);
  // Only a FETCH-state ack that is not overridden by a redirect is kept.
  assign fetch_push = (state_q == ST_FETCH) && imem_ack && !redirect;
  assign halted     = (state_q == ST_HALTED);

  // Next-state and next-PC; redirect dominates stall, ack and halt.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d    = target_pc;
      state_d = (req_active && !imem_ack) ? ST_SQUASH : ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            if (is_hlt) begin
              state_d = ST_HALTED;
            end else begin
              pc_d = pc_next(pc_q);
              // OUT stays occupied, so this word parks in PEND: pause.
              if (if_valid && !consume) state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT:   if (consume)  state_d = ST_FETCH;
        ST_SQUASH: if (imem_ack) state_d = ST_FETCH;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  // FSM state and architectural PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Capture the stale address when an unacked FETCH request gets squashed,
  // so imem_addr stays stable until memory answers that request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_addr_q <= RESET_PC;
    end else if (redirect && (state_q == ST_FETCH) && !imem_ack) begin
      squash_addr_q <= pc_q;
    end
  end

  fetch_skid_buf u_skid (
    .clk            (clk),
    .rst            (rst),
    .flush          (redirect),
    .push           (fetch_push),
    .push_instr     (imem_rdata),
    .push_pc        (pc_q),
    .push_pc_plus_2 (pc_next(pc_q)),
    .pop            (!stall),
    .out_valid      (if_valid),
    .out_instr      (if_instr),
    .out_pc         (if_pc),
    .out_pc_plus_2  (if_pc_plus_2)
  );

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Owns the architectural PC and drives instruction fetch to instruction memory over a req/ack handshake.
- Presents one fetched instruction per cycle, with its PC and PC+2, to decode.
- Consumes the branch resolver's redirect (taken-branch target) and the hazard unit's stall.
- Squashes wrong-path and in-flight fetches on redirect.
- Stops fetching on a HLT opcode until redirected or reset.

Parameters:
- RESET_PC, 16'h0000, PC fetched first after reset.
- HLT_OPCODE, 4'hF, value of instr[15:12] that halts fetch.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- redirect  input  1  taken branch (Branch & (BranchImm|BranchReg)), valid this cycle
- redirect_pc  input  16  branch target; bit 0 forced to 0 internally
- stall  input  1  decode cannot accept; hold presented instruction
- imem_req  output  1  fetch request, held until imem_ack
- imem_addr  output  16  fetch address, stable while imem_req=1
- imem_ack  input  1  read data valid; may assert in any cycle imem_req=1, including the first
- imem_rdata  input  16  instruction word, valid with imem_ack
- if_valid  output  1  if_instr/if_pc/if_pc_plus_2 valid
- if_instr  output  16  fetched instruction
- if_pc  output  16  address of if_instr
- if_pc_plus_2  output  16  if_pc + 2, modulo 2^16
- halted  output  1  fetch stopped on HLT

Behaviour:
- Reset (async, any time, mid-request included):
  - pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pc_plus_2=0; halted=0.
  - Pending and squash cleared; state FETCH. An ack arriving during reset is ignored.
- First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
- Storage: output register (OUT) plus one pending register (PEND); at most 2 fetched-but-unconsumed instructions.
- OUT is consumed on any edge with if_valid=1 and stall=0.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - On ack, not squashed: word goes to OUT if OUT is empty or consumed this edge, else to PEND; pc<=pc+2 (wraps FFFE->0000).
    - On ack with PEND full after the edge: go to WAIT.
  - WAIT: imem_req=0. Return to FETCH when PEND drains into OUT; the new req is issued the following cycle.
  - SQUASH: imem_req=1, address held at the stale pc. Ack data is discarded. Next state FETCH at the redirect pc; no idle cycle between them.
  - HALTED: imem_req=0, halted=1.
- Halt: a non-squashed ack with imem_rdata[15:12]==HLT_OPCODE is still delivered to decode, pc is not incremented, and the next state is HALTED.
- Redirect (priority over stall, ack and halt in the same cycle):
  - if_valid<=0; PEND dropped; pc<=redirect_pc; halted<=0.
  - If a request is outstanding and not acked this cycle: go to SQUASH.
  - If acked this cycle: that data is discarded; go to FETCH.
  - From WAIT or HALTED: go to FETCH.
- A redirect while already in SQUASH updates pc only; still one discard.
- PC+2 arithmetic is unsigned 16-bit, no overflow flag.
- Stall with if_valid=0 has no effect.
- OUT refill on the consume edge gives zero-bubble throughput when ack is single-cycle.
- Never drop a non-squashed instruction. Never present an instruction fetched before a redirect after that redirect.

Decomposition:
- Shared package: HLT_OPCODE, the RESET_PC default, a 2-bit fetch state encoding (FETCH, WAIT, SQUASH, HALTED), and the 16-bit word width.
- One sub-module: fetch_skid_buf, holding OUT+PEND (instr, pc, valid) with push/pop/flush ports. The FSM and pc register stay in the top.

Test Plan:
- Reset, ack every cycle, stall=0, memory returns addr+16'h1000 -> imem_addr 0000,0002,0004...; if_instr 1000,1002,1004 on consecutive cycles; if_pc_plus_2 = if_pc+2.
- Stall held 4 cycles while ack continues -> OUT holds; the next word lands in PEND; imem_req low (WAIT); on release the words come out in order with no loss or duplicate.
- Redirect to 16'h0041 while a req to 0006 is outstanding with ack delayed 3 cycles -> 0006 data discarded, if_valid=0; next imem_addr=0040; first delivered if_pc=0040.
- imem_rdata=F000 at 0008 -> delivered once; halted=1; imem_req=0 indefinitely. Then redirect to 0020 -> halted=0 and fetch resumes at 0020.
- pc=FFFE -> if_pc_plus_2=0000; next imem_addr=0000.
- Assert rst mid-request (imem_req=1, ack pending) -> all outputs immediately at reset values; after release, imem_addr=RESET_PC.
